// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for a character-LCD bus; owns EN setup/pulse/hold/exec timing.
// Optional round-robin tie-break when LCD_ARB_RR_EN is defined (fixed req0 priority otherwise).
module lcd_bus_arbiter #(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 25,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] db0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] db1,
  output logic       ack1,
  output logic       busy,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DADOS
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             en_q, en_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             grant0, grant1;
  logic             long_cmd;
  logic             timer_done;

`ifdef LCD_ARB_RR_EN
  // rr_q names the requester favoured on the next tie; reset favours req0.
  logic rr_q, rr_d;

  always_comb begin
    grant0 = req0 && (!req1 || !rr_q);
    grant1 = req1 && !grant0;
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_IDLE) begin
      if (grant0)      rr_d = 1'b1;
      else if (grant1) rr_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    grant0 = req0;
    grant1 = req1 && !req0;
  end
`endif

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  assign long_cmd   = !rs_q && (db_q[7:2] == 6'd0) && (db_q != 8'd0);
  assign timer_done = (timer_q == CNT_ONE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rs_d    = rs_q;
    db_d    = db_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          state_d = ST_SETUP;
          timer_d = LD_SETUP;
          rs_d    = rs0;
          db_d    = db0;
          ack0_d  = 1'b1;
        end else if (grant1) begin
          state_d = ST_SETUP;
          timer_d = LD_SETUP;
          rs_d    = rs1;
          db_d    = db1;
          ack1_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_d = ST_PULSE;
          timer_d = LD_PULSE;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (timer_done) begin
          state_d = ST_HOLD;
          timer_d = LD_HOLD;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          state_d = ST_WAIT;
          timer_d = long_cmd ? LD_LONG : LD_EXEC;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (timer_done) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    // Outputs are registered copies of the upcoming state so they align with it.
    en_d   = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      en_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      en_q    <= en_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign LCD_EN    = en_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DADOS = db_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed commands feed an expected queue; a monitor
// times each acked transaction on the LCD pins and compares against it.
module tb_lcd_bus_arbiter;

  localparam int T_SETUP = 2;
  localparam int T_PULSE = 4;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 10;
  localparam int T_LONG  = 50;
  localparam int LEN_S   = T_SETUP + T_PULSE + T_HOLD + T_EXEC;  // 18
  localparam int LEN_L   = T_SETUP + T_PULSE + T_HOLD + T_LONG;  // 58
  localparam int W       = 19;  // {who, rs, db[7:0], len[8:0]}; len 0 = aborted by reset

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] db0 = 8'h00, db1 = 8'h00;
  logic       ack0, ack1, busy, LCD_EN, LCD_RS, LCD_RW;
  logic [7:0] LCD_DADOS;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  lcd_bus_arbiter #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC), .T_EXEC_LONG(T_LONG), .CNT_W(17)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .req0(req0), .rs0(rs0), .db0(db0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .db1(db1), .ack1(ack1),
    .busy(busy), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_DADOS(LCD_DADOS)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0] e;
    int len, setup, pulse, pulses, aborted, bad_bus, extra_ack;
    logic prev_en;
    forever begin
      @(negedge Clock);
      if (!Reset && (ack0 || ack1)) begin
        check("ack_exclusive", {31'd0, ack0 && ack1}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {31'd0, ack1}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("grant_who", {31'd0, ack1}, {31'd0, e[18]});
          check("latched_rs_db", {23'd0, LCD_RS, LCD_DADOS}, {23'd0, e[17:9]});
          len = 1; setup = LCD_EN ? 0 : 1; pulse = 0; pulses = 0;
          aborted = 0; bad_bus = 0; extra_ack = 0; prev_en = LCD_EN;
          for (int c = 0; c < 300; c++) begin
            @(negedge Clock);
            if (Reset) begin aborted = 1; break; end
            if (LCD_RS !== e[17] || LCD_DADOS !== e[16:9]) bad_bus = 1;
            if (!busy) break;
            len++;
            if (ack0 || ack1) extra_ack = 1;
            if (LCD_EN) begin
              pulse++;
              if (!prev_en) pulses++;
            end else if (pulses == 0) begin
              setup++;
            end
            prev_en = LCD_EN;
          end
          if (e[8:0] == 9'd0) begin
            check("abort_by_reset", aborted, 1);
          end else begin
            check("not_aborted", aborted, 0);
            check("busy_len", len, {23'd0, e[8:0]});
            check("setup_cycles", setup, T_SETUP);
            check("pulse_cycles", pulse, T_PULSE);
            check("en_pulse_count", pulses, 1);
            check("bus_stable", bad_bus, 0);
            check("single_ack", extra_ack, 0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input bit who, input logic rs, input logic [7:0] db, input int len);
    int got;
    exp_q.push_back({who, rs, db, 9'(len)});
    if (!who) begin req0 = 1'b1; rs0 = rs; db0 = db; end
    else      begin req1 = 1'b1; rs1 = rs; db1 = db; end
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge Clock); #1;
      if ((!who && ack0) || (who && ack1)) begin got = 1; break; end
    end
    check("ack_seen", got, 1);
    if (!who) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      if (!busy && exp_q.size() == 0) break;
    end
    @(posedge Clock); #1;
  endtask

  // Hold both requests; drop each after its target number of acks.
  task automatic hold_both(input int t0, input int t1);
    int c0, c1;
    c0 = 0; c1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 3000 && (req0 || req1); c++) begin
      @(posedge Clock); #1;
      if (ack0) begin c0++; if (c0 == t0) req0 = 1'b0; end
      if (ack1) begin c1++; if (c1 == t1) req1 = 1'b0; end
    end
    check("hold_both_done", {30'd0, req0, req1}, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int lat, got;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_outputs", {21'd0, LCD_EN, LCD_RS, LCD_RW, LCD_DADOS, ack0, ack1, busy}, 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    repeat (2) @(posedge Clock); #1;

    // Basic instruction, then long/short boundary cases.
    issue(1'b0, 1'b0, 8'h38, LEN_S); wait_idle();
    issue(1'b0, 1'b0, 8'h01, LEN_L); wait_idle();
    issue(1'b0, 1'b0, 8'h00, LEN_S); wait_idle();
    issue(1'b0, 1'b0, 8'h03, LEN_L); wait_idle();
    issue(1'b0, 1'b1, 8'h02, LEN_S); wait_idle();
    issue(1'b0, 1'b0, 8'h04, LEN_S); wait_idle();

    // req1 arrives while busy: served after one IDLE cycle.
    issue(1'b0, 1'b0, 8'h0C, LEN_S);
    repeat (5) @(posedge Clock); #1;
    exp_q.push_back({1'b1, 1'b1, 8'h55, 9'(LEN_S)});
    req1 = 1'b1; rs1 = 1'b1; db1 = 8'h55;
    lat = 5; got = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge Clock); #1; lat++;
      if (ack1) begin got = 1; break; end
    end
    req1 = 1'b0;
    check("t6_ack1_seen", got, 1);
    check("t6_ack1_latency", lat, LEN_S + 1);
    wait_idle();

    // Reset during PULSE aborts the command.
    issue(1'b0, 1'b0, 8'h38, 0);
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge Clock); #1;
      if (LCD_EN) begin got = 1; break; end
    end
    check("t5_en_seen", got, 1);
    @(posedge Clock); #2;
    Reset = 1'b1;
    #1;
    check("t5_async_rst", {20'd0, LCD_EN, busy, LCD_DADOS, LCD_RS, ack0, ack1}, 32'd0);
    repeat (2) @(posedge Clock); #1;
    check("t5_rst_held", {28'd0, LCD_EN, busy, ack0, ack1}, 32'd0);
    Reset = 1'b0;
    repeat (2) @(posedge Clock); #1;
    issue(1'b1, 1'b1, 8'h42, LEN_S); wait_idle();

    // Simultaneous requests: req0 first, then req1.
    rs0 = 1'b0; db0 = 8'h06; rs1 = 1'b1; db1 = 8'h41;
    exp_q.push_back({1'b0, 1'b0, 8'h06, 9'(LEN_S)});
    exp_q.push_back({1'b1, 1'b1, 8'h41, 9'(LEN_S)});
    hold_both(1, 1);
    wait_idle();

    // Continuous contention.
    rs0 = 1'b1; db0 = 8'h30; rs1 = 1'b1; db1 = 8'h41;
`ifdef LCD_ARB_RR_EN
    exp_q.push_back({1'b0, 1'b1, 8'h30, 9'(LEN_S)});
    exp_q.push_back({1'b1, 1'b1, 8'h41, 9'(LEN_S)});
    exp_q.push_back({1'b0, 1'b1, 8'h30, 9'(LEN_S)});
    exp_q.push_back({1'b1, 1'b1, 8'h41, 9'(LEN_S)});
    hold_both(2, 2);
`else
    exp_q.push_back({1'b0, 1'b1, 8'h30, 9'(LEN_S)});
    exp_q.push_back({1'b0, 1'b1, 8'h30, 9'(LEN_S)});
    exp_q.push_back({1'b0, 1'b1, 8'h30, 9'(LEN_S)});
    exp_q.push_back({1'b1, 1'b1, 8'h41, 9'(LEN_S)});
    hold_both(3, 1);
`endif
    wait_idle();

    check("queue_drained", exp_q.size(), 0);
    check("rw_low", {31'd0, LCD_RW}, 32'd0);
    check("final_idle", {30'd0, busy, LCD_EN}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
